// File: rtl/parallel_io_ctrl.sv
// Memory-mapped parallel I/O controller for the single-cycle MIPS datapath.
// Decodes a 16-word window and provides synchronised inputs, registered outputs and sticky change flags.
module parallel_io_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                N_IN        = 2,
  parameter int                N_OUT       = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = 8'hF0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    we,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_wren,
  output logic [DATA_W-1:0]       rdata,
  input  logic [N_IN*DATA_W-1:0]  din,
  output logic [N_OUT*DATA_W-1:0] dout,
  output logic [N_IN-1:0]         chg_flags,
  output logic                    chg_irq
);

  localparam int               CNT_W      = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_MAX   = CNT_W'(SYNC_STAGES + 1);
  localparam logic [3:0]       STATUS_OFF = 4'hF;
  localparam int               OUT_OFF    = 8;

  logic                    is_io;
  logic [3:0]              off;
  logic                    w1c;
  logic                    warm_done;

  logic [DATA_W-1:0]       sync_q [N_IN][SYNC_STAGES];
  logic [DATA_W-1:0]       prev_q [N_IN];
  logic [DATA_W-1:0]       dout_q [N_OUT];
  logic [DATA_W-1:0]       dout_d [N_OUT];
  logic [N_IN-1:0]         flags_q;
  logic [N_IN-1:0]         flags_d;
  logic [N_IN-1:0]         changed;
  logic [N_IN-1:0]         clr_mask;
  logic [CNT_W-1:0]        warm_q;
  logic [CNT_W-1:0]        warm_d;
  logic [DATA_W-1:0]       status;

  assign is_io    = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign off      = address[3:0];
  assign mem_wren = we & ~is_io;
  assign w1c      = we & is_io & (off == STATUS_OFF);

  // Warm-up masks change detection until the synchroniser and prev registers hold real data.
  assign warm_done = (warm_q == WARM_MAX);
  assign warm_d    = warm_done ? warm_q : warm_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        prev_q[i] <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[i][s] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync_q[i][0] <= din[i*DATA_W +: DATA_W];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[i][s] <= sync_q[i][s-1];
        end
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    changed = '0;
    for (int i = 0; i < N_IN; i++) begin
      changed[i] = warm_done && (sync_q[i][SYNC_STAGES-1] != prev_q[i]);
    end
  end

  // A new change outranks a W1C landing in the same cycle, so no event is lost.
  always_comb begin
    clr_mask = w1c ? wdata[N_IN-1:0] : '0;
    flags_d  = (flags_q & ~clr_mask) | changed;
  end

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      dout_d[k] = dout_q[k];
      if (we && is_io && (off == 4'(OUT_OFF + k))) begin
        dout_d[k] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      warm_q  <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        dout_q[k] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      warm_q  <= warm_d;
      for (int k = 0; k < N_OUT; k++) begin
        dout_q[k] <= dout_d[k];
      end
    end
  end

  always_comb begin
    status             = '0;
    status[N_IN-1:0]   = flags_q;
  end

  // Unmapped offsets inside the window fall through to zero.
  always_comb begin
    rdata = '0;
    if (!is_io) begin
      rdata = mem_rdata;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (off == 4'(i)) rdata = sync_q[i][SYNC_STAGES-1];
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (off == 4'(OUT_OFF + k)) rdata = dout_q[k];
      end
      if (off == STATUS_OFF) rdata = status;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_dout
    assign dout[k*DATA_W +: DATA_W] = dout_q[k];
  end

  assign chg_flags = flags_q;
  assign chg_irq   = |flags_q;

endmodule

// File: doc/parallel_io_ctrl.md
Name: parallel_io_ctrl

Overview:
- Parametrised memory-mapped parallel I/O controller for the single-cycle MIPS datapath.
- It sits between the ALU address / register-file write data and the data RAM.
- It decodes an I/O window at the top of the address space and provides N_IN synchronised input ports and N_OUT registered output ports.
- Sticky per-input change flags with write-1-to-clear and an interrupt-style summary output extend the earlier single-port IN/OUT pair.

Parameters:
- DATA_W, 8, data width of bus, ports and status register
- ADDR_W, 8, address width
- N_IN, 2, number of input ports (1..8, and N_IN <= DATA_W)
- N_OUT, 2, number of output ports (1..7)
- IO_BASE, 8'hF0, base of 16-word I/O window; low 4 bits must be 0
- SYNC_STAGES, 2, input synchroniser depth (>= 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- address  in  ADDR_W  ALU result used as data address
- we  in  1  store strobe from control unit (MemWrite)
- wdata  in  DATA_W  store data (register rd2)
- mem_rdata  in  DATA_W  data RAM read data
- mem_wren  out  1  data RAM write enable
- rdata  out  DATA_W  load data to writeback mux
- din  in  N_IN*DATA_W  external inputs; port i = din[i*DATA_W +: DATA_W]
- dout  out  N_OUT*DATA_W  registered external outputs; same packing as din
- chg_flags  out  N_IN  sticky change flags
- chg_irq  out  1  OR of chg_flags

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk. Reset has priority over every write and flag update.
- Reset values:
  - dout, all sync stages, prev-value registers, chg_flags: 0.
  - chg_irq: 0.
  - warm-up counter: 0.
- Decode:
  - is_io = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]).
  - off = address[3:0].
- Address map:
  - off 0..N_IN-1: input port off (read-only).
  - off 8..8+N_OUT-1: output port off-8 (read/write).
  - off 15: status, bits [N_IN-1:0] = chg_flags, upper bits 0; reads return flags, writes are W1C.
  - Any other off inside the window is unmapped: reads return 0, writes are ignored.
- mem_wren: combinational, = we & ~is_io. RAM is never written for I/O addresses.
- rdata: combinational, zero-cycle latency.
  - ~is_io: mem_rdata.
  - Input port: last sync stage of that port.
  - Output port: current dout register (readback).
  - Status: flags.
  - Unmapped: 0.
- Output write: on rising clk with we=1, is_io=1 and off = 8+k (k < N_OUT), dout port k <= wdata. Visible on dout and on readback the next cycle.
- Input synchroniser:
  - Each port passes through SYNC_STAGES flops.
  - A din change set up before edge 1 appears on rdata after edge SYNC_STAGES.
- Change detection:
  - prev[i] <= last stage every cycle.
  - changed[i] = (last stage != prev[i]), evaluated only when warm_done=1.
  - Flag i sets on edge SYNC_STAGES+1 after the din change.
- Warm-up:
  - A counter runs from 0 up to SYNC_STAGES+1 after reset, then holds; warm_done = (count == SYNC_STAGES+1).
  - changed is ignored until warm_done, so nonzero din at reset does not raise spurious flags.
- Flag update per clk:
  - flag[i] <= (flag[i] & ~(w1c & wdata[i])) | changed[i], where w1c = we & is_io & off==15.
  - A set and a clear in the same cycle: the set wins.
- chg_irq: combinational OR of registered flags.
- Reset asserted mid-operation clears flags, dout and sync stages and restarts warm-up; any write in that cycle is discarded.

Test Plan:
- Reset with din={8'h5A,8'h3C} held → dout=0, flags=0 through warm-up; after SYNC_STAGES edges, reads of 0xF0=3C and 0xF1=5A; flags stay 00.
- Store 8'hA5 to 0xF8 → mem_wren=0; dout[7:0]=A5 next cycle; load 0xF8 returns A5. Store 8'h11 to 0x20 → mem_wren=1, dout unchanged.
- After warm-up, change din port0 3C→3D at cycle t → rdata@0xF0=3D after edge t+2; flags=01 and chg_irq=1 after edge t+3; write 8'h01 to 0xFF → flags=00, chg_irq=0.
- Port1 change arriving in the same cycle as a W1C of 8'h02 → flag1 remains 1.
- Load from 0xF5 (unmapped) → rdata=0; store to 0xF5 → no dout or flag change, mem_wren=0.
- Assert rst_n=0 for one cycle with dout=A5 and flags=03 → dout=0, flags=0, no flag set for SYNC_STAGES+1 cycles afterwards.
